tdd_frame_sched: RTL and testbench

- Sequences TDD frame timing for the AXI-to-stream datapath.
- Consumes the software-programmed frame and window registers (frame_len, frame_adj, tstart, tend, rstart, rend, tddmode).
- Generates the per-sample frame counter, the tx/rx window enables and the start-of-frame strobe.
- Executes one-shot frame-length adjustments and returns adj_pending to the register block.

---
 rtl/tdd_frame_sched.sv | 145 ++++++++++++++
 tb/tb_tdd_frame_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdd_frame_sched.sv
// TDD frame sequencer: per-sample frame counter, tx/rx window enables, sof strobe, one-shot length adjust.
// Optional overlap masking and sticky overlap_err are built when TDD_OVERLAP_CHK_EN is defined.
module tdd_frame_sched #(
   parameter int unsigned CW  = 24,
   parameter int unsigned FNW = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           tick,
   input  logic [CW-1:0]  frame_len,
   input  logic [CW-1:0]  frame_adj,
   input  logic           adj_req,
   input  logic [CW-1:0]  tstart,
   input  logic [CW-1:0]  tend,
   input  logic [CW-1:0]  rstart,
   input  logic [CW-1:0]  rend,
   output logic [CW-1:0]  cnt,
   output logic [FNW-1:0] frame_num,
   output logic           sof,
   output logic           tx_win,
   output logic           rx_win,
   output logic           adj_pending
`ifdef TDD_OVERLAP_CHK_EN
   ,
   output logic           overlap_err
`endif
);

   localparam int unsigned SW = CW + 2;

   typedef enum logic {StIdle, StRun} state_t;

   state_t        state_q;
   logic [CW-1:0] len_s;
   logic [CW-1:0] tstart_s, tend_s, rstart_s, rend_s;

   logic [CW-1:0]        len_nom;
   logic [CW-1:0]        adj_len;
   logic signed [SW-1:0] adj_sum;
   logic                 last;
   logic                 tx_hit, rx_hit;

   function automatic logic win_hit(input logic [CW-1:0] s, input logic [CW-1:0] e,
                                    input logic [CW-1:0] c);
      if (s <= e) return (c >= s) && (c <= e);
      else        return (c >= s) || (c <= e);
   endfunction

   assign len_nom = (frame_len < CW'(2)) ? CW'(2) : frame_len;

   // Two guard bits: the sum can neither overflow nor be misread as negative.
   assign adj_sum = $signed({2'b00, frame_len}) + $signed({{2{frame_adj[CW-1]}}, frame_adj});

   always_comb begin
      if (adj_sum[SW-1])                      adj_len = CW'(2);
      else if (adj_sum[CW])                   adj_len = '1;
      else if (adj_sum[CW-1:0] < CW'(2))      adj_len = CW'(2);
      else                                    adj_len = adj_sum[CW-1:0];
   end

   assign last   = (cnt == len_s - CW'(1));
   assign tx_hit = win_hit(tstart_s, tend_s, cnt);
   assign rx_hit = win_hit(rstart_s, rend_s, cnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         len_s       <= '0;
         tstart_s    <= '0;
         tend_s      <= '0;
         rstart_s    <= '0;
         rend_s      <= '0;
         cnt         <= '0;
         frame_num   <= '0;
         sof         <= 1'b0;
         tx_win      <= 1'b0;
         rx_win      <= 1'b0;
         adj_pending <= 1'b0;
`ifdef TDD_OVERLAP_CHK_EN
         overlap_err <= 1'b0;
`endif
      end else begin
         sof <= 1'b0;
         if (adj_req) adj_pending <= 1'b1;
         unique case (state_q)
            StIdle: begin
               cnt    <= '0;
               tx_win <= 1'b0;
               rx_win <= 1'b0;
               if (en) begin
                  state_q  <= StRun;
                  len_s    <= len_nom;
                  tstart_s <= tstart;
                  tend_s   <= tend;
                  rstart_s <= rstart;
                  rend_s   <= rend;
                  sof      <= 1'b1;
               end
            end
            StRun: begin
               if (!en) begin
                  state_q <= StIdle;
                  cnt     <= '0;
                  tx_win  <= 1'b0;
                  rx_win  <= 1'b0;
`ifdef TDD_OVERLAP_CHK_EN
                  overlap_err <= 1'b0;
`endif
               end else begin
`ifdef TDD_OVERLAP_CHK_EN
                  tx_win <= tx_hit & ~rx_hit;
                  if (tx_hit && rx_hit) overlap_err <= 1'b1;
`else
                  tx_win <= tx_hit;
`endif
                  rx_win <= rx_hit;
                  if (tick) begin
                     if (last) begin
                        cnt       <= '0;
                        frame_num <= frame_num + FNW'(1);
                        sof       <= 1'b1;
                        tstart_s  <= tstart;
                        tend_s    <= tend;
                        rstart_s  <= rstart;
                        rend_s    <= rend;
                        if (adj_pending) begin
                           len_s <= adj_len;
                           // A request landing on the consuming wrap arms the next frame.
                           adj_pending <= adj_req;
                        end else begin
                           len_s <= len_nom;
                        end
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_tdd_frame_sched.sv
// Directed bench for tdd_frame_sched: frame counting, windows, adjustments, disable and reset.
module tb_tdd_frame_sched;

   localparam int CW  = 24;
   localparam int FNW = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic           tick;
   logic [CW-1:0]  frame_len, frame_adj, tstart, tend, rstart, rend;
   logic           adj_req;
   logic [CW-1:0]  cnt;
   logic [FNW-1:0] frame_num;
   logic           sof, tx_win, rx_win, adj_pending;
`ifdef TDD_OVERLAP_CHK_EN
   logic           overlap_err;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   tdd_frame_sched #(.CW(CW), .FNW(FNW)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .tick        (tick),
      .frame_len   (frame_len),
      .frame_adj   (frame_adj),
      .adj_req     (adj_req),
      .tstart      (tstart),
      .tend        (tend),
      .rstart      (rstart),
      .rend        (rend),
      .cnt         (cnt),
      .frame_num   (frame_num),
      .sof         (sof),
      .tx_win      (tx_win),
      .rx_win      (rx_win),
      .adj_pending (adj_pending)
`ifdef TDD_OVERLAP_CHK_EN
      ,
      .overlap_err (overlap_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_frame(input string tag, input int c, input bit s, input bit t, input bit r);
      chk({tag, ".cnt"}, 64'(cnt), 64'(c));
      chk({tag, ".sof"}, 64'(sof), 64'(s));
      chk({tag, ".tx"}, 64'(tx_win), 64'(t));
      chk({tag, ".rx"}, 64'(rx_win), 64'(r));
   endtask

   initial begin
      int p, te;
      bit ov, t;
      rst = 1'b1; en = 1'b0; tick = 1'b0; adj_req = 1'b0;
      frame_len = 24'd10; frame_adj = '0;
      tstart = 24'd0; tend = 24'd4; rstart = 24'd5; rend = 24'd9;
      #2 rst = 1'b0;
      step();
      step();
      chk_frame("reset", 0, 0, 0, 0);
      chk("reset.frame_num", 64'(frame_num), 64'd0);
      chk("reset.adj_pending", 64'(adj_pending), 64'd0);
`ifdef TDD_OVERLAP_CHK_EN
      chk("reset.overlap_err", 64'(overlap_err), 64'd0);
`endif
      rst = 1'b1;
      step();
      chk_frame("idle", 0, 0, 0, 0);

      // Basic frame, tick every cycle
      en = 1'b1; tick = 1'b1;
      step();
      chk_frame("entry", 0, 1, 0, 0);
      chk("entry.frame_num", 64'(frame_num), 64'd0);
      for (int k = 1; k <= 26; k++) begin
         step();
         p = (k - 1) % 10;
         chk_frame("basic", k % 10, (k % 10) == 0, p <= 4, p >= 5);
         chk("basic.frame_num", 64'(frame_num), 64'(k / 10));
      end

      // Disable at cnt=6, then re-enable
      en = 1'b0;
      step();
      chk_frame("dis", 0, 0, 0, 0);
      chk("dis.frame_num", 64'(frame_num), 64'd2);
      step();
      chk("dis.hold", 64'(cnt), 64'd0);
      en = 1'b1;
      step();
      chk_frame("reen", 0, 1, 0, 0);
      chk("reen.frame_num", 64'(frame_num), 64'd2);
      step();
      chk_frame("reen1", 1, 0, 1, 0);

      // Adjustment -3: frame 1 lasts 7, frame 2 lasts 10
      en = 1'b0;
      step();
      en = 1'b1; frame_adj = 24'hFFFFFD;
      step();
      chk_frame("adj.entry", 0, 1, 0, 0);
      adj_req = 1'b1;
      step();
      adj_req = 1'b0;
      chk("adj.pend_set", 64'(adj_pending), 64'd1);
      repeat (8) step();
      chk("adj.cnt9", 64'(cnt), 64'd9);
      chk("adj.pend_held", 64'(adj_pending), 64'd1);
      step();
      chk("adj.wrap_sof", 64'(sof), 64'd1);
      chk("adj.pend_clr", 64'(adj_pending), 64'd0);
      chk("adj.fn3", 64'(frame_num), 64'd3);
      repeat (6) step();
      chk("adj.cnt6", 64'(cnt), 64'd6);
      step();
      chk("adj.short_wrap_cnt", 64'(cnt), 64'd0);
      chk("adj.short_wrap_sof", 64'(sof), 64'd1);
      chk("adj.fn4", 64'(frame_num), 64'd4);
      repeat (7) step();
      chk("adj.nominal_cnt7", 64'(cnt), 64'd7);
      repeat (2) step();
      step();
      chk("adj.nominal_wrap_sof", 64'(sof), 64'd1);
      chk("adj.fn5", 64'(frame_num), 64'd5);

      // Adjustment -20 clamps to 2; request coincident with consuming wrap
      frame_adj = 24'hFFFFEC; adj_req = 1'b1;
      step();
      adj_req = 1'b0;
      repeat (8) step();
      chk("clamp.cnt9", 64'(cnt), 64'd9);
      adj_req = 1'b1;
      step();
      adj_req = 1'b0;
      chk("clamp.wrap_sof", 64'(sof), 64'd1);
      chk("clamp.pend_kept", 64'(adj_pending), 64'd1);
      chk("clamp.fn6", 64'(frame_num), 64'd6);
      step();
      chk("clamp.cnt1", 64'(cnt), 64'd1);
      step();
      chk_frame("clamp.len2_wrap", 0, 1, 1, 0);
      chk("clamp.pend_clr", 64'(adj_pending), 64'd0);
      chk("clamp.fn7", 64'(frame_num), 64'd7);
      step();
      step();
      chk("clamp.len2_again_sof", 64'(sof), 64'd1);
      chk("clamp.fn8", 64'(frame_num), 64'd8);
      repeat (9) step();
      chk("clamp.back10_cnt9", 64'(cnt), 64'd9);
      step();
      chk("clamp.fn9", 64'(frame_num), 64'd9);

      // Upper clamp: 16777214 + 5 -> 16777215
      frame_len = 24'hFFFFFE; frame_adj = 24'd5; adj_req = 1'b1;
      step();
      adj_req = 1'b0;
      repeat (8) step();
      step();
      chk("upper.wrap_sof", 64'(sof), 64'd1);
      chk("upper.fn10", 64'(frame_num), 64'd10);
      chk("upper.len_s", 64'(dut.len_s), 64'hFFFFFF);
      repeat (12) step();
      chk("upper.cnt12", 64'(cnt), 64'd12);

      // Wrapped tx window, mid-frame tend write applies after next sof
      en = 1'b0; frame_len = 24'd10; frame_adj = '0;
      tstart = 24'd8; tend = 24'd1; rstart = 24'd4; rend = 24'd7;
      step();
      en = 1'b1;
      step();
      chk_frame("wrapwin.entry", 0, 1, 0, 0);
      for (int k = 1; k <= 14; k++) begin
         if (k == 4) tend = 24'd3;
         step();
         p  = (k - 1) % 10;
         te = (k - 1 >= 10) ? 3 : 1;
         chk_frame("wrapwin", k % 10, (k % 10) == 0, (p >= 8) || (p <= te), (p >= 4) && (p <= 7));
      end

      // Overlapping windows
      en = 1'b0; tstart = 24'd0; tend = 24'd5; rstart = 24'd4; rend = 24'd9;
      step();
      en = 1'b1;
      step();
      chk_frame("ovl.entry", 0, 1, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         step();
         p  = (k - 1) % 10;
         ov = (p >= 4) && (p <= 5);
`ifdef TDD_OVERLAP_CHK_EN
         t = (p <= 5) && !ov;
         chk("ovl.err", 64'(overlap_err), 64'(k >= 5));
`else
         t = (p <= 5);
`endif
         chk_frame("ovl", k % 10, (k % 10) == 0, t, p >= 4);
      end
      en = 1'b0;
      step();
      chk_frame("ovl.dis", 0, 0, 0, 0);
`ifdef TDD_OVERLAP_CHK_EN
      chk("ovl.err_clr", 64'(overlap_err), 64'd0);
`endif

      // Asynchronous reset mid-frame
      en = 1'b1; adj_req = 1'b1;
      step();
      adj_req = 1'b0;
      chk("arst.pend_before", 64'(adj_pending), 64'd1);
      repeat (3) step();
      chk("arst.cnt3", 64'(cnt), 64'd3);
      en = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk_frame("arst", 0, 0, 0, 0);
      chk("arst.frame_num", 64'(frame_num), 64'd0);
      chk("arst.adj_pending", 64'(adj_pending), 64'd0);
      step();
      rst = 1'b1;
      step();
      chk_frame("arst.idle", 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
